// File: rtl/reset_sequencer.sv
// Board-level reset generator: qualifies button and PLL lock, holds reset, then
// releases CHANNELS reset domains in a fixed stagger and records the last cause.
module reset_sequencer #(
  parameter int CHANNELS        = 3,
  parameter int HOLD_CYCLES     = 64,
  parameter int STAGGER_CYCLES  = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk50,
  input  logic                reset,
  input  logic                resetbtn,
  input  logic                pll_locked,
  output logic [CHANNELS-1:0] rst_out,
  output logic                ready,
  output logic [1:0]          cause
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_HOLD    = 2'b01,
    ST_RELEASE = 2'b10,
    ST_RUN     = 2'b11
  } state_e;

  logic            btn_meta_q, btn_sync_q, pll_meta_q, pll_sync_q;
  logic            btn_stable_q;
  logic [DB_W-1:0] db_cnt_q;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CHANNELS-1:0]   rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic [1:0]            cause_q, cause_d;

  logic                  fault_s;
  logic                  step_s;
  logic [CHANNELS-1:0]   rst_shift_s;

  // Two-flop synchronisers for the asynchronous button and lock inputs
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      pll_meta_q <= 1'b0;
      pll_sync_q <= 1'b0;
    end else begin
      btn_meta_q <= resetbtn;
      btn_sync_q <= btn_meta_q;
      pll_meta_q <= pll_locked;
      pll_sync_q <= pll_meta_q;
    end
  end

  // Button debouncer: a level change is accepted only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      btn_stable_q <= 1'b1;
      db_cnt_q     <= {DB_W{1'b0}};
    end else if (btn_sync_q == btn_stable_q) begin
      db_cnt_q     <= {DB_W{1'b0}};
    end else if (db_cnt_q == DB_LAST) begin
      btn_stable_q <= btn_sync_q;
      db_cnt_q     <= {DB_W{1'b0}};
    end else begin
      db_cnt_q     <= db_cnt_q + DB_W'(1);
    end
  end

  assign fault_s = ~btn_stable_q | ~pll_sync_q;
  // Channels clear from bit 0 upward, so a left shift drops the next asserted bit.
  assign rst_shift_s = rst_out_q << 1'b1;
  assign step_s = ((state_q == ST_HOLD)    && (cnt_q == HOLD_LAST)) ||
                  ((state_q == ST_RELEASE) && (cnt_q == STAG_LAST));

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    cause_d   = cause_q;
    case (state_q)
      ST_ASSERT: begin
        rst_out_d = {CHANNELS{1'b1}};
        ready_d   = 1'b0;
        cnt_d     = {CNT_W{1'b0}};
        if (!fault_s) state_d = ST_HOLD;
        else          state_d = ST_ASSERT;
      end
      ST_HOLD, ST_RELEASE: begin
        if (step_s) begin
          cnt_d     = {CNT_W{1'b0}};
          rst_out_d = rst_shift_s;
          if (rst_shift_s == {CHANNELS{1'b0}}) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        rst_out_d = {CHANNELS{1'b0}};
        ready_d   = 1'b1;
      end
      default: begin
        state_d   = ST_ASSERT;
        rst_out_d = {CHANNELS{1'b1}};
        ready_d   = 1'b0;
        cnt_d     = {CNT_W{1'b0}};
      end
    endcase
    // A fault outside ASSERT overrides any progress; lock loss wins over the button.
    if (fault_s && (state_q != ST_ASSERT)) begin
      state_d   = ST_ASSERT;
      rst_out_d = {CHANNELS{1'b1}};
      ready_d   = 1'b0;
      cnt_d     = {CNT_W{1'b0}};
      cause_d   = pll_sync_q ? 2'b01 : 2'b10;
    end else begin
      cause_d   = cause_q;
    end
  end

  // Sequencer state and output registers
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= {CNT_W{1'b0}};
      rst_out_q <= {CHANNELS{1'b1}};
      ready_q   <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      cause_q   <= cause_d;
    end
  end

  assign rst_out = rst_out_q;
  assign ready   = ready_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-on, button debounce, lock glitch,
// mid-release fault, simultaneous faults and asynchronous reset.
module tb_reset_sequencer;

  localparam int CHANNELS = 3;

  logic                clk50;
  logic                reset;
  logic                resetbtn;
  logic                pll_locked;
  logic [CHANNELS-1:0] rst_out;
  logic                ready;
  logic [1:0]          cause;

  int n_total;
  int n_bad;

  reset_sequencer #(
    .CHANNELS        (CHANNELS),
    .HOLD_CYCLES     (8),
    .STAGGER_CYCLES  (4),
    .DEBOUNCE_CYCLES (16)
  ) dut (
    .clk50      (clk50),
    .reset      (reset),
    .resetbtn   (resetbtn),
    .pll_locked (pll_locked),
    .rst_out    (rst_out),
    .ready      (ready),
    .cause      (cause)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_total++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  // HOLD is entered t0_off edges from now; walk the 8+4+4 release timeline.
  task automatic check_seq(input int t0_off);
    tick(t0_off + 7);
    check("seq_t7_rst",    32'(rst_out), 32'h7);
    check("seq_t7_ready",  32'(ready),   32'h0);
    tick(1);
    check("seq_t8_rst",    32'(rst_out), 32'h6);
    tick(3);
    check("seq_t11_rst",   32'(rst_out), 32'h6);
    tick(1);
    check("seq_t12_rst",   32'(rst_out), 32'h4);
    tick(3);
    check("seq_t15_rst",   32'(rst_out), 32'h4);
    check("seq_t15_ready", 32'(ready),   32'h0);
    tick(1);
    check("seq_t16_rst",   32'(rst_out), 32'h0);
    check("seq_t16_ready", 32'(ready),   32'h1);
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    reset      = 1'b1;
    resetbtn   = 1'b1;
    pll_locked = 1'b1;

    // Power-on
    tick(3);
    check("por_rst",   32'(rst_out), 32'h7);
    check("por_ready", 32'(ready),   32'h0);
    check("por_cause", 32'(cause),   32'h0);
    reset = 1'b0;
    check_seq(3);
    check("por_cause_run", 32'(cause), 32'h0);

    // Short button bounces are ignored
    for (int i = 0; i < 3; i++) begin
      resetbtn = 1'b0;
      tick(10);
      resetbtn = 1'b1;
      tick(12);
      check("bounce_rst",   32'(rst_out), 32'h0);
      check("bounce_ready", 32'(ready),   32'h1);
    end

    // Debounced press, long hold, debounced release
    resetbtn = 1'b0;
    tick(18);
    check("press_pre_rst", 32'(rst_out), 32'h0);
    tick(1);
    check("press_rst",     32'(rst_out), 32'h7);
    check("press_cause",   32'(cause),   32'h1);
    check("press_ready",   32'(ready),   32'h0);
    tick(200);
    check("press_hold_rst", 32'(rst_out), 32'h7);
    resetbtn = 1'b1;
    check_seq(19);

    // Single-cycle lock glitch
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    check("glitch_e2_rst", 32'(rst_out), 32'h0);
    tick(1);
    check("glitch_e3_rst", 32'(rst_out), 32'h7);
    check("glitch_cause",  32'(cause),   32'h2);
    check_seq(1);

    // Lock loss in the middle of the release stagger
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(11);
    check("mid_at110",   32'(rst_out), 32'h6);
    pll_locked = 1'b0;
    tick(2);
    check("mid_e2_rst",  32'(rst_out), 32'h6);
    tick(1);
    check("mid_e3_rst",  32'(rst_out), 32'h7);
    check("mid_cause",   32'(cause),   32'h2);
    tick(2);
    pll_locked = 1'b1;
    check_seq(3);

    // Debounced press and lock loss seen on the same edge
    resetbtn = 1'b0;
    tick(16);
    pll_locked = 1'b0;
    tick(2);
    check("simul_pre_rst", 32'(rst_out), 32'h0);
    tick(1);
    check("simul_rst",     32'(rst_out), 32'h7);
    check("simul_cause",   32'(cause),   32'h2);
    resetbtn   = 1'b1;
    pll_locked = 1'b1;
    tick(10);
    check("simul_held_cause", 32'(cause),   32'h2);
    check("simul_held_rst",   32'(rst_out), 32'h7);
    check_seq(9);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    check("arst_rst",   32'(rst_out), 32'h7);
    check("arst_ready", 32'(ready),   32'h0);
    check("arst_cause", 32'(cause),   32'h0);
    reset = 1'b0;
    check_seq(3);
    check("arst_cause_run", 32'(cause), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
